// File: rtl/sgmii_rate_decimator.sv
// sgmii_rate_decimator: collapses each SGMII 10/100 replication period into one qualified byte.
// States: ST_IDLE = waiting for active input, k free-runs | ST_RUN = inside a frame, k tracks the period.
module sgmii_rate_decimator (
    input  logic       i_GClk,
    input  logic       i_ARst_L,
    input  logic [1:0] i2_Speed,
    input  logic       i_RxEN,
    input  logic       i_RxER,
    input  logic [7:0] i8_RxD,
    output logic       o_Valid,
    output logic       o_RxEN,
    output logic       o_RxER,
    output logic [7:0] o8_RxD,
    output logic       o_Sop,
    output logic       o_Eop,
    output logic       o_RepErr,
    output logic       o_SamplingClk
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t     st_q, st_d;
    logic [6:0] k_q, k_d;
    logic [6:0] nlat_q, nlat_d;
    logic [9:0] hold_q, hold_d;
    logic       err_q, err_d;
    logic       first_q, first_d;

    logic       valid_q, valid_d;
    logic       rxen_q, rxen_d;
    logic       rxer_q, rxer_d;
    logic [7:0] rxd_q, rxd_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       rep_q, rep_d;

    logic       active;
    logic [9:0] rx_w;
    logic [6:0] n_spd;
    logic [6:0] k_inc;
    logic       mm;

    assign active = i_RxEN | i_RxER;
    assign rx_w   = {i_RxEN, i_RxER, i8_RxD};
    assign n_spd  = (i2_Speed == 2'b00) ? 7'd100 :
                    (i2_Speed == 2'b01) ? 7'd10  : 7'd1;
    // The >= guard keeps k in range if Nlat shrinks while idling.
    assign k_inc  = (k_q >= nlat_q - 7'd1) ? 7'd0 : k_q + 7'd1;
    assign mm     = (rx_w != hold_q);

    always_comb begin
        st_d    = st_q;
        k_d     = k_inc;
        nlat_d  = nlat_q;
        hold_d  = hold_q;
        err_d   = err_q;
        first_d = first_q;
        valid_d = 1'b0;
        rxen_d  = 1'b0;
        rxer_d  = 1'b0;
        rxd_d   = 8'h00;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        rep_d   = 1'b0;

        case (st_q)
            ST_IDLE: begin
                nlat_d = n_spd;
                if (active) begin
                    hold_d = rx_w;
                    err_d  = 1'b0;
                    st_d   = ST_RUN;
                    if (n_spd == 7'd1) begin
                        k_d     = 7'd0;
                        first_d = 1'b0;
                        valid_d = 1'b1;
                        rxd_d   = i8_RxD;
                        rxen_d  = i_RxEN;
                        rxer_d  = i_RxER;
                        sop_d   = 1'b1;
                    end else begin
                        k_d     = 7'd1;
                        first_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!active) begin
                    // k == 0 is a clean end; anywhere else the period was truncated.
                    st_d  = ST_IDLE;
                    eop_d = 1'b1;
                    rep_d = (k_q != 7'd0);
                end else if (k_q == 7'd0) begin
                    hold_d = rx_w;
                    err_d  = 1'b0;
                    if (nlat_q == 7'd1) begin
                        valid_d = 1'b1;
                        rxd_d   = i8_RxD;
                        rxen_d  = i_RxEN;
                        rxer_d  = i_RxER;
                        sop_d   = first_q;
                        first_d = 1'b0;
                    end
                end else begin
                    err_d = err_q | mm;
                    if (k_q == nlat_q - 7'd1) begin
                        valid_d = 1'b1;
                        rxd_d   = hold_q[7:0];
                        rxen_d  = hold_q[9];
                        rxer_d  = hold_q[8] | err_q | mm;
                        rep_d   = err_q | mm;
                        sop_d   = first_q;
                        first_d = 1'b0;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_GClk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            st_q    <= ST_IDLE;
            k_q     <= 7'd0;
            nlat_q  <= 7'd1;
            hold_q  <= 10'd0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            valid_q <= 1'b0;
            rxen_q  <= 1'b0;
            rxer_q  <= 1'b0;
            rxd_q   <= 8'h00;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            k_q     <= k_d;
            nlat_q  <= nlat_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            first_q <= first_d;
            valid_q <= valid_d;
            rxen_q  <= rxen_d;
            rxer_q  <= rxer_d;
            rxd_q   <= rxd_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            rep_q   <= rep_d;
        end
    end

    assign o_Valid       = valid_q;
    assign o_RxEN        = rxen_q;
    assign o_RxER        = rxer_q;
    assign o8_RxD        = rxd_q;
    assign o_Sop         = sop_q;
    assign o_Eop         = eop_q;
    assign o_RepErr      = rep_q;
    assign o_SamplingClk = (k_q == 7'd0);

endmodule
